uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter DATA_W, default 8: byte width per requester.
REQ-003 Parameter BUSY_TIMEOUT, default 16: maximum cycles allowed between a Send_TX pulse and Tx_Busy rising.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  per-requester request level; held until that requester's grant bit pulses.
REQ-007 data_in  input  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
REQ-008 Tx_Busy  input  1  transmitter busy, already synchronous to clk.
REQ-009 grant  output  N_REQ  registered one-hot, one-cycle pulse: byte of requester i accepted.
REQ-010 Tx_data  output  DATA_W  registered byte presented to the transmitter.
REQ-011 Send_TX  output  1  registered one-cycle start pulse to the transmitter.
REQ-012 active_id  output  clog2(N_REQ)  index of the requester currently being served.
REQ-013 Timeout  output  1  registered one-cycle pulse: Tx_Busy failed to rise within BUSY_TIMEOUT cycles.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with req != 0, the block SHALL select the first set req bit at or after index (last_id+1) mod N_REQ (round-robin).
REQ-016 On the next edge it SHALL pulse grant[sel], load Tx_data <= data_in[sel], set active_id <= sel, set last_id <= sel, and enter SEND.
REQ-017 In SEND with Tx_Busy=0, it SHALL pulse Send_TX for exactly one cycle, clear the timeout counter, and enter WAIT_BUSY.
REQ-018 In SEND with Tx_Busy=1, it SHALL hold SEND without pulsing Send_TX, for an unbounded time.
REQ-019 In WAIT_BUSY, Tx_Busy=1 SHALL move the FSM to WAIT_DONE; otherwise the counter increments.
REQ-020 When the counter reaches BUSY_TIMEOUT-1 with Tx_Busy=0, the block SHALL pulse Timeout, drop the byte without retrying, and return to IDLE.
REQ-021 In WAIT_DONE, Tx_Busy=0 SHALL return the FSM to IDLE.
REQ-022 Tx_data and active_id SHALL hold stable from grant until the next grant.
REQ-023 Minimum latency: req sampled in IDLE at edge k gives grant at k+1 and Send_TX at k+2 when Tx_Busy=0.
REQ-024 Only one grant SHALL be outstanding; requests arriving outside IDLE wait and are arbitrated on the next IDLE cycle.
REQ-025 A req bit that falls before its grant SHALL be ignored, with no grant and no transfer.
REQ-026 The counter SHALL be clog2(BUSY_TIMEOUT)+1 bits and SHALL saturate, never wrap.
REQ-027 Round-robin SHALL wrap from index N_REQ-1 to index 0.

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-transfer, SHALL immediately force: state=IDLE, grant=0, Send_TX=0, Timeout=0, Tx_data=0, active_id=0, counter=0.
REQ-029 Reset SHALL set last_id to N_REQ-1, so requester 0 has first priority after reset.
REQ-030 Release of rst_n SHALL take effect synchronously; the first arbitration happens on the first edge after release.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding and the default DATA_W.
REQ-032 The round-robin selector SHALL be a combinational sub-module rr_select (inputs req and last_id; outputs sel and valid), reusable elsewhere in the UART path.

Verification
REQ-033 Reset then req=4'b0001, data_in[7:0]=8'hA5, Tx_Busy=0 -> grant=0001 at cycle 1, Send_TX and Tx_data=A5 at cycle 2.
REQ-034 req=4'b1111 held, Tx_Busy rises 2 cycles after each Send_TX and falls 10 cycles later -> grants in order 0,1,2,3,0, one per transfer.
REQ-035 Tx_Busy held 1 at grant for 5 cycles -> Send_TX stays 0 during those cycles, then pulses once on the cycle after Tx_Busy falls.
REQ-036 Tx_Busy never rises, BUSY_TIMEOUT=16 -> Timeout pulses 16 cycles after Send_TX, FSM returns to IDLE, and the next requester is granted.
REQ-037 rst_n pulled low during WAIT_DONE -> all outputs are 0 immediately; after release with req=4'b0100, requester 2 is granted.
REQ-038 req[1] pulsed for 1 cycle while the FSM is in WAIT_DONE -> no grant[1] ever issued.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART transmit path:
//             arbiter FSM state encoding and the default byte width.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default width of one transmitted byte
    localparam int c_DATA_W_DEFAULT = 8;

    // Arbiter FSM state encoding
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 2'd0;
    localparam state_t c_ST_SEND      = 2'd1;
    localparam state_t c_ST_WAIT_BUSY = 2'd2;
    localparam state_t c_ST_WAIT_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : rr_select
//  Brief    : Combinational round-robin selector. Picks the first set request
//             bit at or after (last_id+1) mod N_REQ, wrapping to index 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  sel,
    output logic             valid
);

    // One extra bit holds sums up to 2*N_REQ-1 without overflow
    localparam int                 c_SUM_W = ID_W + 1;
    localparam logic [c_SUM_W-1:0] c_N     = c_SUM_W'(N_REQ);

    logic [c_SUM_W-1:0]   w_shift;
    logic [2*N_REQ-1:0]   w_dbl;
    logic [N_REQ-1:0]     w_rot;
    logic [c_SUM_W-1:0]   w_off;
    logic [c_SUM_W-1:0]   w_sum;

    // Rotate the request vector so bit 0 is the requester right after last_id
    assign w_shift = {1'b0, last_id} + c_SUM_W'(1);
    assign w_dbl   = {req, req} >> w_shift;
    assign w_rot   = w_dbl[N_REQ-1:0];

    // Lowest set bit of the rotated vector is the distance to the winner
    always_comb begin
        w_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_SUM_W'(j);
            end
        end
    end

    // Undo the rotation, folding back into 0..N_REQ-1
    assign w_sum = w_shift + w_off;
    assign sel   = (w_sum >= c_N) ? ID_W'(w_sum - c_N) : ID_W'(w_sum);
    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin arbiter sharing one UART transmitter among N_REQ
//             requesters. Grants one byte at a time, issues the start pulse
//             once the transmitter is free, and watches for the busy
//             handshake with a saturating timeout counter.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = c_DATA_W_DEFAULT,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    data_in,
    input  logic                       Tx_Busy,
    output logic [N_REQ-1:0]           grant,
    output logic [DATA_W-1:0]          Tx_data,
    output logic                       Send_TX,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       Timeout
);

    localparam int                 c_ID_W     = $clog2(N_REQ);
    localparam int                 c_CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [c_ID_W-1:0]  c_LAST_RST = c_ID_W'(N_REQ - 1);

    // Registered state
    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_send;
    logic [c_ID_W-1:0]   r_active_id;
    logic [c_ID_W-1:0]   r_last_id;
    logic                r_timeout;
    logic [c_CNT_W-1:0]  r_cnt;

    // Next-state values
    state_t              w_state_nxt;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic [DATA_W-1:0]   w_tx_data_nxt;
    logic                w_send_nxt;
    logic [c_ID_W-1:0]   w_active_id_nxt;
    logic [c_ID_W-1:0]   w_last_id_nxt;
    logic                w_timeout_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    // Arbitration result
    logic [c_ID_W-1:0]   w_sel;
    logic                w_valid;
    logic [DATA_W-1:0]   w_bytes [N_REQ];

    // Unpack the flat data bus into one byte per requester
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_bytes[i] = data_in[i*DATA_W +: DATA_W];
    end

    rr_select #(
        .N_REQ   (N_REQ),
        .ID_W    (c_ID_W)
    ) u_rr_select (
        .req     (req),
        .last_id (r_last_id),
        .sel     (w_sel),
        .valid   (w_valid)
    );

    // Next-state and output decode; pulses default low, held values default to hold
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = '0;
        w_send_nxt      = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_active_id_nxt = r_active_id;
        w_last_id_nxt   = r_last_id;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            c_ST_IDLE: begin
                // Requests are only looked at here, so a request that drops
                // while another transfer is in flight is never granted
                if (w_valid) begin
                    w_grant_nxt     = N_REQ'(1) << w_sel;
                    w_tx_data_nxt   = w_bytes[w_sel];
                    w_active_id_nxt = w_sel;
                    w_last_id_nxt   = w_sel;
                    w_state_nxt     = c_ST_SEND;
                end
            end

            c_ST_SEND: begin
                // Transmitter still finishing someone else's byte: wait indefinitely
                if (!Tx_Busy) begin
                    w_send_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_WAIT_BUSY;
                end
            end

            c_ST_WAIT_BUSY: begin
                if (Tx_Busy) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end else if (r_cnt >= c_CNT_LAST) begin
                    // Transmitter never acknowledged: drop the byte
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_ST_IDLE;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            c_ST_WAIT_DONE: begin
                if (!Tx_Busy) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= '0;
            r_tx_data   <= '0;
            r_send      <= 1'b0;
            r_active_id <= '0;
            r_last_id   <= c_LAST_RST;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_send      <= w_send_nxt;
            r_active_id <= w_active_id_nxt;
            r_last_id   <= w_last_id_nxt;
            r_timeout   <= w_timeout_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign grant     = r_grant;
    assign Tx_data   = r_tx_data;
    assign Send_TX   = r_send;
    assign active_id = r_active_id;
    assign Timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Directed self-checking bench for uart_tx_arbiter
//             (N_REQ=4, DATA_W=8, BUSY_TIMEOUT=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        Tx_Busy;
    logic [3:0]  grant;
    logic [7:0]  Tx_data;
    logic        Send_TX;
    logic [1:0]  active_id;
    logic        Timeout;

    int checks;
    int errors;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .Tx_Busy   (Tx_Busy),
        .grant     (grant),
        .Tx_data   (Tx_data),
        .Send_TX   (Send_TX),
        .active_id (active_id),
        .Timeout   (Timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        req     = '0;
        Tx_Busy = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output logic [3:0] g, output bit ok);
        int n;
        ok = 1'b0;
        g  = '0;
        n  = 0;
        while (!ok && n < 64) begin
            tick();
            n++;
            if (grant != 4'b0000) begin
                g  = grant;
                ok = 1'b1;
            end
        end
    endtask

    // From WAIT_BUSY: acknowledge, stay busy a cycle, then release
    task automatic finish_transfer();
        Tx_Busy = 1'b1;
        tick();
        tick();
        Tx_Busy = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", Send_TX); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", Timeout); end
        checks++; if (Tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h expected 00", Tx_data); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_id); end
    endtask

    task automatic test_min_latency();
        data_in = 32'h0000_00A5;
        req     = 4'b0001;
        Tx_Busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lat_grant: got %b expected 0001", grant); end
        checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL lat_send_early: got %b expected 0", Send_TX); end
        req = 4'b0000;
        tick();
        checks++; if (Send_TX !== 1'b1) begin errors++; $display("FAIL lat_send: got %b expected 1", Send_TX); end
        checks++; if (Tx_data !== 8'hA5) begin errors++; $display("FAIL lat_txdata: got %h expected a5", Tx_data); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL lat_grant_pulse: got %b expected 0000", grant); end
        tick();
        checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL lat_send_pulse: got %b expected 0", Send_TX); end
        finish_transfer();
    endtask

    task automatic test_round_robin();
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  exp_byte  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0]  g;
        logic [3:0]  exp_g;
        bit          ok;
        int          extra;
        apply_reset();
        data_in = 32'h4433_2211;
        req     = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << exp_order[t];
            wait_grant(g, ok);
            checks++; if (!ok || g !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, g, exp_g); end
            checks++; if (Tx_data !== exp_byte[exp_order[t]]) begin errors++; $display("FAIL rr_txdata[%0d]: got %h expected %h", t, Tx_data, exp_byte[exp_order[t]]); end
            checks++; if (active_id !== 2'(exp_order[t])) begin errors++; $display("FAIL rr_active[%0d]: got %0d expected %0d", t, active_id, exp_order[t]); end
            tick();
            checks++; if (Send_TX !== 1'b1) begin errors++; $display("FAIL rr_send[%0d]: got %b expected 1", t, Send_TX); end
            tick();
            Tx_Busy = 1'b1;
            extra = 0;
            repeat (10) begin
                tick();
                if (grant != 4'b0000) extra++;
            end
            Tx_Busy = 1'b0;
            checks++; if (extra !== 0) begin errors++; $display("FAIL rr_single_grant[%0d]: got %0d extra expected 0", t, extra); end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_busy_hold();
        logic [3:0] g;
        bit         ok;
        apply_reset();
        data_in = 32'h0000_005C;
        Tx_Busy = 1'b1;
        req     = 4'b0001;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL hold_grant: got %b expected 0001", g); end
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL hold_send_low[%0d]: got %b expected 0", i, Send_TX); end
        end
        Tx_Busy = 1'b0;
        tick();
        checks++; if (Send_TX !== 1'b1) begin errors++; $display("FAIL hold_send: got %b expected 1", Send_TX); end
        checks++; if (Tx_data !== 8'h5C) begin errors++; $display("FAIL hold_txdata: got %h expected 5c", Tx_data); end
        tick();
        checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL hold_send_pulse: got %b expected 0", Send_TX); end
        finish_transfer();
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        bit         ok;
        int         early;
        apply_reset();
        data_in = 32'h0000_BBAA;
        Tx_Busy = 1'b0;
        req     = 4'b0011;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL to_first_grant: got %b expected 0001", g); end
        req = 4'b0010;
        tick();
        checks++; if (Send_TX !== 1'b1) begin errors++; $display("FAIL to_send: got %b expected 1", Send_TX); end
        early = 0;
        repeat (15) begin
            tick();
            if (Timeout) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d pulses expected 0", early); end
        tick();
        checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", Timeout); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_no_retry: got %b expected 0000", grant); end
        tick();
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", Timeout); end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_next_grant: got %b expected 0010", grant); end
        checks++; if (Tx_data !== 8'hBB) begin errors++; $display("FAIL to_next_txdata: got %h expected bb", Tx_data); end
        checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL to_next_active: got %0d expected 1", active_id); end
        req = 4'b0000;
        tick();
        finish_transfer();
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        bit         ok;
        apply_reset();
        data_in = 32'h0000_7E00;
        Tx_Busy = 1'b0;
        req     = 4'b0010;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 4'b0010) begin errors++; $display("FAIL rm_grant: got %b expected 0010", g); end
        req = 4'b0000;
        tick();
        Tx_Busy = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_grant_clr: got %b expected 0000", grant); end
        checks++; if (Send_TX !== 1'b0) begin errors++; $display("FAIL rm_send_clr: got %b expected 0", Send_TX); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout_clr: got %b expected 0", Timeout); end
        checks++; if (Tx_data !== 8'h00) begin errors++; $display("FAIL rm_txdata_clr: got %h expected 00", Tx_data); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rm_active_clr: got %0d expected 0", active_id); end
        Tx_Busy = 1'b0;
        data_in = 32'h00C3_0000;
        req     = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rm_regrant: got %b expected 0100", grant); end
        checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL rm_active: got %0d expected 2", active_id); end
        checks++; if (Tx_data !== 8'hC3) begin errors++; $display("FAIL rm_txdata: got %h expected c3", Tx_data); end
        req = 4'b0000;
        tick();
        finish_transfer();
    endtask

    task automatic test_ignored_pulse();
        logic [3:0] g;
        bit         ok;
        int         gcount;
        apply_reset();
        data_in = 32'h0055_6611;
        Tx_Busy = 1'b0;
        req     = 4'b0001;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL ign_grant: got %b expected 0001", g); end
        req = 4'b0000;
        tick();
        checks++; if (Send_TX !== 1'b1) begin errors++; $display("FAIL ign_send: got %b expected 1", Send_TX); end
        Tx_Busy = 1'b1;
        tick();
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        Tx_Busy = 1'b0;
        gcount = 0;
        repeat (10) begin
            tick();
            if (grant != 4'b0000) gcount++;
        end
        checks++; if (gcount !== 0) begin errors++; $display("FAIL ign_no_grant: got %0d grants expected 0", gcount); end
        req = 4'b0100;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL ign_followup: got %b expected 0100", g); end
        checks++; if (Tx_data !== 8'h55) begin errors++; $display("FAIL ign_followup_data: got %h expected 55", Tx_data); end
        req = 4'b0000;
        tick();
        finish_transfer();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        req     = '0;
        data_in = '0;
        Tx_Busy = 1'b0;
        test_reset();
        test_min_latency();
        test_round_robin();
        test_busy_hold();
        test_timeout();
        test_reset_mid();
        test_ignored_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
